// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Entry fields are sized for the largest supported register file and latency range.
package fwd_hazard_pkg;

    localparam int MAX_REG_ADDR_W = 8;
    localparam int MAX_LAT_W      = 4;

    localparam int FWD_SEL_RF = 0;

    localparam logic [MAX_LAT_W-1:0] RS_ALU  = MAX_LAT_W'(0);
    localparam logic [MAX_LAT_W-1:0] RS_LOAD = MAX_LAT_W'(1);

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] rd;
        logic                      reg_write;
        logic [MAX_LAT_W-1:0]      ready_stage;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_hazard_if.sv
// ID-stage <-> hazard unit signal bundle; the ID stage is the master.
interface fwd_hazard_if #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 6,
    parameter int FWD_STAGES = 2,
    parameter int LAT_W      = 2,
    parameter int CNT_W      = 32
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic                                  id_valid;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0]    id_rs;
    logic [NUM_SRC-1:0]                    id_rs_used;
    logic [REG_ADDR_W-1:0]                 id_rd;
    logic                                  id_reg_write;
    logic [LAT_W-1:0]                      id_ready_stage;
    logic                                  id_long_op;
    logic                                  lu_wb_valid;
    logic [REG_ADDR_W-1:0]                 lu_wb_rd;
    logic                                  ext_stall;
    logic                                  flush;
    logic [NUM_SRC-1:0][SEL_W-1:0]         fwd_sel;
    logic                                  hazard_stall;
    logic [CNT_W-1:0]                      stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_ready_stage,
               id_long_op, lu_wb_valid, lu_wb_rd, ext_stall, flush,
        input  fwd_sel, hazard_stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_ready_stage,
               id_long_op, lu_wb_valid, lu_wb_rd, ext_stall, flush,
        output fwd_sel, hazard_stall, stall_count
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for results owed by long-latency units.
// A set and a clear of the same register in one cycle leaves it busy.
module reg_scoreboard #(
    parameter int ADDR_W = 6,
    parameter int NUM_RD = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           set_en,
    input  logic [ADDR_W-1:0]              set_addr,
    input  logic                           clr_en,
    input  logic [ADDR_W-1:0]              clr_addr,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0]              rd_busy
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Register 0 is hardwired zero, so it is never marked busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_busy[r] = busy_q[rd_addr[r]];
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forward-select and stall generation for the ID stage: tracks in-flight destinations
// through FWD_STAGES slots and long-latency results through a register scoreboard.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 6,
    parameter int FWD_STAGES = 2,
    parameter int LAT_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    fwd_hazard_if.slave  bus
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    fwd_entry_t [FWD_STAGES-1:0]          stage_q;
    fwd_entry_t                           new_entry;
    logic [NUM_SRC-1:0][SEL_W-1:0]        sel;
    logic [NUM_SRC-1:0]                   data_haz;
    logic                                 busy_haz;
    logic                                 hazard;
    logic                                 issue;
    logic [CNT_W-1:0]                     stall_cnt_q;
    logic [NUM_SRC:0][REG_ADDR_W-1:0]     sb_addr;
    logic [NUM_SRC:0]                     sb_busy;

    // Scan oldest to youngest so the youngest matching stage overwrites older ones.
    always_comb begin
        sel      = '0;
        data_haz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel[i] = SEL_W'(FWD_SEL_RF);
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (stage_q[k].valid && stage_q[k].reg_write &&
                    (stage_q[k].rd != '0) &&
                    (stage_q[k].rd == MAX_REG_ADDR_W'(bus.id_rs[i])) &&
                    bus.id_rs_used[i]) begin
                    sel[i]      = SEL_W'(k + 1);
                    data_haz[i] = (stage_q[k].ready_stage > MAX_LAT_W'(k));
                end
            end
        end
    end

    // Last read port checks the destination for a write-after-write on a busy register.
    always_comb begin
        sb_addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sb_addr[i] = bus.id_rs[i];
        end
        sb_addr[NUM_SRC] = bus.id_rd;
    end

    always_comb begin
        busy_haz = sb_busy[NUM_SRC] & bus.id_reg_write;
        for (int i = 0; i < NUM_SRC; i++) begin
            busy_haz = busy_haz | (sb_busy[i] & bus.id_rs_used[i]);
        end
    end

    assign hazard = bus.id_valid && !bus.flush && ((|data_haz) || busy_haz);
    assign issue  = bus.id_valid && !hazard && !bus.flush && !bus.ext_stall;

    reg_scoreboard #(
        .ADDR_W (REG_ADDR_W),
        .NUM_RD (NUM_SRC + 1)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (issue && bus.id_long_op),
        .set_addr (bus.id_rd),
        .clr_en   (bus.lu_wb_valid),
        .clr_addr (bus.lu_wb_rd),
        .rd_addr  (sb_addr),
        .rd_busy  (sb_busy)
    );

    // Long ops never forward through the pipeline; their result arrives via the scoreboard.
    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid       = 1'b1;
            new_entry.rd          = MAX_REG_ADDR_W'(bus.id_rd);
            new_entry.reg_write   = bus.id_reg_write && !bus.id_long_op;
            new_entry.ready_stage = MAX_LAT_W'(bus.id_ready_stage);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
        end else if (!bus.ext_stall) begin
            for (int k = FWD_STAGES - 1; k > 0; k--) begin
                stage_q[k] <= stage_q[k-1];
            end
            stage_q[0] <= new_entry;
            if (hazard && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_sel      = sel;
    assign bus.hazard_stall = hazard;
    assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;
    import fwd_hazard_pkg::*;

    localparam logic [1:0] ALU  = 2'(RS_ALU);
    localparam logic [1:0] LOAD = 2'(RS_LOAD);

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fwd_hazard_if #(.NUM_SRC(2), .REG_ADDR_W(6), .FWD_STAGES(2), .LAT_W(2), .CNT_W(32)) bus ();

    fwd_hazard_unit #(
        .NUM_SRC    (2),
        .REG_ADDR_W (6),
        .FWD_STAGES (2),
        .LAT_W      (2),
        .CNT_W      (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one ID instruction; side-band controls return to idle unless set afterwards.
    task automatic applyStimulus(input logic valid,
                                 input logic [5:0] rs0, input logic u0,
                                 input logic [5:0] rs1, input logic u1,
                                 input logic [5:0] rd, input logic wr,
                                 input logic [1:0] rdy, input logic lng);
        bus.id_valid       = valid;
        bus.id_rs[0]       = rs0;
        bus.id_rs[1]       = rs1;
        bus.id_rs_used     = {u1, u0};
        bus.id_rd          = rd;
        bus.id_reg_write   = wr;
        bus.id_ready_stage = rdy;
        bus.id_long_op     = lng;
        bus.lu_wb_valid    = 1'b0;
        bus.lu_wb_rd       = 6'd0;
        bus.ext_stall      = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitSample();
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, ALU, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_stall", 32'(bus.hazard_stall), 32'd0);
        checkOutput("reset_sel0", 32'(bus.fwd_sel[0]), 32'd0);
        checkOutput("reset_count", bus.stall_count, 32'd0);
        waitSample();
        reset_n = 1'b1;
        advanceCycle();

        // ALU dependency chain
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("first_cycle_stall", 32'(bus.hazard_stall), 32'd0);
        checkOutput("first_cycle_sel0", 32'(bus.fwd_sel[0]), 32'd0);
        advanceCycle();
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd2, 1'b1, 6'd6, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("alu_fwd_ex", 32'(bus.fwd_sel[0]), 32'd1);
        checkOutput("alu_fwd_rf", 32'(bus.fwd_sel[1]), 32'd0);
        checkOutput("alu_no_stall", 32'(bus.hazard_stall), 32'd0);
        advanceCycle();
        applyStimulus(1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 6'd8, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("alu_fwd_mem", 32'(bus.fwd_sel[0]), 32'd2);
        checkOutput("alu_fwd_ex_src1", 32'(bus.fwd_sel[1]), 32'd1);
        advanceCycle();

        // Load-use: one bubble, then forward from MEM
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b0, 6'd7, 1'b1, LOAD, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd2, 1'b1, 6'd7, 1'b1, 6'd10, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("lu_stall", 32'(bus.hazard_stall), 32'd1);
        advanceCycle();
        waitSample();
        checkOutput("lu_released", 32'(bus.hazard_stall), 32'd0);
        checkOutput("lu_fwd_mem", 32'(bus.fwd_sel[1]), 32'd2);
        checkOutput("lu_count", bus.stall_count, 32'd1);
        advanceCycle();

        // Youngest writer wins; x0 never forwards
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9, 1'b1, ALU, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9, 1'b1, ALU, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd9, 1'b1, 6'd9, 1'b1, 6'd11, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("prio_youngest0", 32'(bus.fwd_sel[0]), 32'd1);
        checkOutput("prio_youngest1", 32'(bus.fwd_sel[1]), 32'd1);
        advanceCycle();
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd0, 1'b1, ALU, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd12, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("x0_sel0", 32'(bus.fwd_sel[0]), 32'd0);
        checkOutput("x0_sel1", 32'(bus.fwd_sel[1]), 32'd0);
        checkOutput("x0_stall", 32'(bus.hazard_stall), 32'd0);
        advanceCycle();

        // Long op on x3; source x12 matches EX but is not read
        applyStimulus(1'b1, 6'd12, 1'b0, 6'd1, 1'b1, 6'd3, 1'b1, ALU, 1'b1);
        waitSample();
        checkOutput("unused_src_sel", 32'(bus.fwd_sel[0]), 32'd0);
        checkOutput("div_issue_stall", 32'(bus.hazard_stall), 32'd0);
        advanceCycle();
        applyStimulus(1'b1, 6'd3, 1'b1, 6'd1, 1'b1, 6'd13, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("busy_stall", 32'(bus.hazard_stall), 32'd1);
        advanceCycle();
        bus.lu_wb_valid = 1'b1;
        bus.lu_wb_rd    = 6'd3;
        waitSample();
        checkOutput("busy_stall_wb_cycle", 32'(bus.hazard_stall), 32'd1);
        advanceCycle();
        applyStimulus(1'b1, 6'd3, 1'b1, 6'd1, 1'b1, 6'd13, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("busy_released", 32'(bus.hazard_stall), 32'd0);
        checkOutput("busy_fwd_rf", 32'(bus.fwd_sel[0]), 32'd0);
        checkOutput("busy_count", bus.stall_count, 32'd3);
        advanceCycle();

        // WAW on a busy x4
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1, ALU, 1'b1);
        advanceCycle();
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("waw_stall", 32'(bus.hazard_stall), 32'd1);
        advanceCycle();

        // Set and clear of x6 in the same cycle leaves it busy
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd6, 1'b1, ALU, 1'b1);
        bus.lu_wb_valid = 1'b1;
        bus.lu_wb_rd    = 6'd6;
        waitSample();
        checkOutput("setclr_issue", 32'(bus.hazard_stall), 32'd0);
        advanceCycle();
        applyStimulus(1'b1, 6'd6, 1'b1, 6'd1, 1'b1, 6'd14, 1'b1, ALU, 1'b0);
        bus.lu_wb_valid = 1'b1;
        bus.lu_wb_rd    = 6'd4;
        waitSample();
        checkOutput("setclr_busy", 32'(bus.hazard_stall), 32'd1);
        advanceCycle();
        applyStimulus(1'b1, 6'd4, 1'b1, 6'd1, 1'b1, 6'd14, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("x4_cleared", 32'(bus.hazard_stall), 32'd0);
        checkOutput("setclr_count", bus.stall_count, 32'd5);
        advanceCycle();
        applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, ALU, 1'b0);
        bus.lu_wb_valid = 1'b1;
        bus.lu_wb_rd    = 6'd6;
        advanceCycle();

        // ext_stall freezes entries and the counter while a hazard is pending
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd20, 1'b1, ALU, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd21, 1'b1, LOAD, 1'b0);
        advanceCycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 6'd20, 1'b1, 6'd21, 1'b1, 6'd0, 1'b0, ALU, 1'b0);
            bus.ext_stall = 1'b1;
            waitSample();
            checkOutput("frz_sel0", 32'(bus.fwd_sel[0]), 32'd2);
            checkOutput("frz_stall", 32'(bus.hazard_stall), 32'd1);
            checkOutput("frz_count", bus.stall_count, 32'd5);
            advanceCycle();
        end
        applyStimulus(1'b1, 6'd20, 1'b1, 6'd21, 1'b1, 6'd0, 1'b0, ALU, 1'b0);
        waitSample();
        checkOutput("unfrz_sel0", 32'(bus.fwd_sel[0]), 32'd2);
        checkOutput("unfrz_stall", 32'(bus.hazard_stall), 32'd1);
        advanceCycle();
        waitSample();
        checkOutput("post_frz_sel0", 32'(bus.fwd_sel[0]), 32'd0);
        checkOutput("post_frz_sel1", 32'(bus.fwd_sel[1]), 32'd2);
        checkOutput("post_frz_count", bus.stall_count, 32'd6);
        advanceCycle();

        // Flush of a stalled instruction lets a bubble in
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd22, 1'b1, LOAD, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd22, 1'b1, 6'd1, 1'b1, 6'd23, 1'b1, ALU, 1'b0);
        bus.flush = 1'b1;
        waitSample();
        checkOutput("flush_stall", 32'(bus.hazard_stall), 32'd0);
        advanceCycle();
        applyStimulus(1'b1, 6'd22, 1'b1, 6'd23, 1'b1, 6'd0, 1'b0, ALU, 1'b0);
        waitSample();
        checkOutput("flush_sel0", 32'(bus.fwd_sel[0]), 32'd2);
        checkOutput("flush_bubble", 32'(bus.fwd_sel[1]), 32'd0);
        checkOutput("flush_count", bus.stall_count, 32'd6);
        advanceCycle();

        // Asynchronous reset in the middle of a load-use stall
        applyStimulus(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd25, 1'b1, LOAD, 1'b0);
        advanceCycle();
        applyStimulus(1'b1, 6'd25, 1'b1, 6'd2, 1'b1, 6'd26, 1'b1, ALU, 1'b0);
        waitSample();
        checkOutput("pre_reset_stall", 32'(bus.hazard_stall), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_stall", 32'(bus.hazard_stall), 32'd0);
        checkOutput("async_rst_sel0", 32'(bus.fwd_sel[0]), 32'd0);
        checkOutput("async_rst_count", bus.stall_count, 32'd0);
        advanceCycle();
        waitSample();
        reset_n = 1'b1;
        advanceCycle();
        waitSample();
        checkOutput("post_rst_stall", 32'(bus.hazard_stall), 32'd0);
        checkOutput("post_rst_sel0", 32'(bus.fwd_sel[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX/MEM forwarding unit.
- Internally tracks destination registers of in-flight instructions through FWD_STAGES pipeline slots, plus a scoreboard for long-latency units (DIV/FP).
- Generates per-source forward selects, load-use/long-latency stalls and a stall-cycle counter for the ID stage.
- Sits beside the ID/EX pipeline register; the operand muxes in EX consume fwd_sel.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (3 for fused FP ops)
- REG_ADDR_W, 6, register address width (int + FP file)
- FWD_STAGES, 2, number of tracked stages after ID (stage 0 = EX, 1 = MEM, ...)
- LAT_W, 2, width of the per-instruction ready-stage field
- CNT_W, 32, width of the stall counter

Ports:
- clk, input, 1, system clock
- reset_n, input, 1, asynchronous active-low reset
- id_valid, input, 1, valid instruction in ID
- id_rs, input, NUM_SRC x REG_ADDR_W, source register addresses
- id_rs_used, input, NUM_SRC, source actually read
- id_rd, input, REG_ADDR_W, destination register
- id_reg_write, input, 1, instruction writes rd
- id_ready_stage, input, LAT_W, stage index whose end produces the result (ALU 0, load 1)
- id_long_op, input, 1, instruction goes to a long-latency unit
- lu_wb_valid, input, 1, long-latency unit writes back this cycle
- lu_wb_rd, input, REG_ADDR_W, long-latency writeback register
- ext_stall, input, 1, pipeline-wide freeze (memory wait)
- flush, input, 1, kill the ID instruction (branch redirect)
- fwd_sel, output, NUM_SRC x $clog2(FWD_STAGES+1), 0 = register file, k = forward from stage k-1
- hazard_stall, output, 1, hold IF/ID, inject bubble into EX
- stall_count, output, CNT_W, saturating count of hazard_stall cycles

Behaviour:
- Reset (async, reset_n low): all stage entries invalid, scoreboard cleared, stall_count = 0. As a result fwd_sel = 0 and hazard_stall = 0 while in reset and on the first cycle after it.
- Stage entry fields: valid, rd, reg_write, ready_stage.
- Entry "matches" source i when valid && reg_write && rd != 0 && rd == id_rs[i] && id_rs_used[i].
- Forwarding (combinational from registered state): fwd_sel[i] = k+1, where k is the lowest-index (youngest) matching stage. No match gives 0. A younger match always wins over an older one.
- Data hazard: youngest match at stage k with ready_stage > k means the data is not yet produced.
- Busy hazard: scoreboard[id_rs[i]] set for a used source, or scoreboard[id_rd] set with id_reg_write (WAW).
- hazard_stall = id_valid && !flush && (any data hazard || any busy hazard). While hazard_stall is high, fwd_sel values are don't-care.
- Issue condition: id_valid && !hazard_stall && !flush && !ext_stall.
- Clock edge when ext_stall = 1: entries, scoreboard set-path and stall_count are frozen. A lu_wb_valid clear is still applied.
- Clock edge otherwise:
  - entries shift (stage k -> k+1; the oldest entry drops out).
  - stage 0 loads the ID instruction if it issues, otherwise a bubble (valid = 0).
  - an issuing long op loads into stage 0 with reg_write = 0 and sets scoreboard[id_rd]. rd = 0 never sets the scoreboard.
- Scoreboard clear: lu_wb_valid clears scoreboard[lu_wb_rd]. Set and clear of the same register in one cycle results in set.
- The scoreboard is not cleared by flush: older long ops always complete.
- stall_count increments on each non-frozen cycle with hazard_stall = 1 and saturates at all-ones.
- Register 0: never matches, never stalls.
- Reset mid-operation discards all entries and scoreboard state immediately.

Decomposition:
- Package fwd_hazard_pkg holds:
  - fwd_entry_t struct (valid, rd, reg_write, ready_stage)
  - FWD_SEL_RF = 0 constant
  - ready-stage constants RS_ALU = 0, RS_LOAD = 1
- One sub-module, reg_scoreboard: per-register busy bits with set/clear ports and a read port for NUM_SRC+1 addresses.
- Stage shift register and match/priority logic stay in the top module.

Test Plan:
- ALU dependency: ADD x5 (ready 0) issues, next ADD reads rs1 = x5 -> no stall, fwd_sel[0] = 1. One instruction later -> fwd_sel[0] = 2.
- Load-use: LW x7 (ready 1), next instruction reads rs2 = x7 -> hazard_stall high exactly 1 cycle, then fwd_sel[1] = 2, stall_count = 1.
- Priority and x0: two consecutive writes to x9 then a read of x9 -> fwd_sel = 1 (youngest). Write to x0 then read x0 -> fwd_sel = 0, no stall.
- Long op: DIV x3 issues, reader of x3 -> stall until lu_wb_valid with rd = 3, then issues with fwd_sel = 0. A WAW write to x3 also stalls. Set and clear in the same cycle leaves busy.
- ext_stall: hold 3 cycles with entries valid -> fwd_sel unchanged, stall_count unchanged. flush on a stalled instruction -> hazard_stall drops, bubble enters stage 0.
- Reset mid-load-use stall: reset_n low -> hazard_stall = 0, fwd_sel = 0, stall_count = 0 immediately (asynchronous).
